// File: rtl/ltc2315_spi_emulator.sv
// ltc2315_spi_emulator: device-side model of the LTC2315 serial interface.
// Answers a reader's CS/sck with a 16-bit frame {0, sample, zeros} on sdo, MSB
// first, shifted on sck falling edges. Samples come from a one-entry buffer
// with valid/ready handshake; a last-sample register is replayed on underrun.
// Optional: define LTC2315_EMU_RAMP_EN to add ramp_mode and an internal 12-bit
// ramp source for loopback self-test.
module ltc2315_spi_emulator #(
   parameter int DATA_W      = 12,
   parameter int FRAME_BITS  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk_100,
   input  logic              reset,
`ifdef LTC2315_EMU_RAMP_EN
   input  logic              ramp_mode,
`endif
   input  logic              CS,
   input  logic              sck,
   output logic              sdo,
   output logic              sdo_oe,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              sample_valid,
   output logic              sample_ready,
   output logic              frame_done,
   output logic              underrun,
   output logic [15:0]       frame_cnt
);

   localparam int CNT_W = $clog2(FRAME_BITS);
   localparam int PAD_W = FRAME_BITS - 1 - DATA_W;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t                state, state_n;
   logic [SYNC_STAGES-1:0] cs_sync, sck_sync;
   logic                  cs_d, sck_d;
   logic                  cs_fall, cs_rise, sck_fall;
   logic [FRAME_BITS-1:0] shift_reg, shift_n, word;
   logic [CNT_W-1:0]      bit_cnt, cnt_n;
   logic                  sdo_n, oe_n, done_n, und_n;
   logic [15:0]           fcnt_n;
   logic                  buf_full, buf_full_n;
   logic [DATA_W-1:0]     buf_data, buf_data_n, last_sample, last_n;
   logic                  use_ramp, consume, push;
`ifdef LTC2315_EMU_RAMP_EN
   logic [11:0]           ramp, ramp_n;
   assign use_ramp = ramp_mode;
`else
   assign use_ramp = 1'b0;
`endif

   function automatic logic [FRAME_BITS-1:0] frame_of(input logic [DATA_W-1:0] s);
      return FRAME_BITS'(s) << PAD_W;
   endfunction

   assign cs_fall  = cs_d & ~cs_sync[SYNC_STAGES-1];
   assign cs_rise  = ~cs_d & cs_sync[SYNC_STAGES-1];
   assign sck_fall = sck_d & ~sck_sync[SYNC_STAGES-1];

   // A frame start frees the buffer in the same cycle, so a waiting sample can land
   assign consume      = cs_fall & (state == IDLE) & ~use_ramp;
   assign sample_ready = ~buf_full | consume;
   assign push         = sample_valid & sample_ready;

   // Pin synchronizers and one-flop edge detectors (idle high)
   always_ff @(posedge clk_100) begin
      if (reset) begin
         cs_sync  <= '1;
         sck_sync <= '1;
         cs_d     <= 1'b1;
         sck_d    <= 1'b1;
      end else begin
         cs_sync  <= {cs_sync[SYNC_STAGES-2:0], CS};
         sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
         cs_d     <= cs_sync[SYNC_STAGES-1];
         sck_d    <= sck_sync[SYNC_STAGES-1];
      end
   end

   // State and registered datapath/outputs
   always_ff @(posedge clk_100) begin
      if (reset) begin
         state       <= IDLE;
         shift_reg   <= '0;
         bit_cnt     <= '0;
         sdo         <= 1'b0;
         sdo_oe      <= 1'b0;
         frame_done  <= 1'b0;
         underrun    <= 1'b0;
         frame_cnt   <= '0;
         buf_full    <= 1'b0;
         buf_data    <= '0;
         last_sample <= '0;
`ifdef LTC2315_EMU_RAMP_EN
         ramp        <= '0;
`endif
      end else begin
         state       <= state_n;
         shift_reg   <= shift_n;
         bit_cnt     <= cnt_n;
         sdo         <= sdo_n;
         sdo_oe      <= oe_n;
         frame_done  <= done_n;
         underrun    <= und_n;
         frame_cnt   <= fcnt_n;
         buf_full    <= buf_full_n;
         buf_data    <= buf_data_n;
         last_sample <= last_n;
`ifdef LTC2315_EMU_RAMP_EN
         ramp        <= ramp_n;
`endif
      end
   end

   // Next-state, shifter, buffer and pulse logic
   always_comb begin
      state_n    = state;
      shift_n    = shift_reg;
      cnt_n      = bit_cnt;
      sdo_n      = sdo;
      oe_n       = sdo_oe;
      done_n     = 1'b0;
      und_n      = 1'b0;
      fcnt_n     = frame_cnt;
      buf_full_n = buf_full;
      buf_data_n = buf_data;
      last_n     = last_sample;
      word       = '0;
`ifdef LTC2315_EMU_RAMP_EN
      ramp_n     = ramp;
`endif

      case (state)
         IDLE: begin
            sdo_n = 1'b0;
            oe_n  = 1'b0;
            if (cs_fall) begin
`ifdef LTC2315_EMU_RAMP_EN
               if (use_ramp) begin
                  word = frame_of(DATA_W'(ramp));
               end else
`endif
               if (buf_full) begin
                  word   = frame_of(buf_data);
                  last_n = buf_data;
               end else begin
                  word  = frame_of(last_sample);
                  und_n = 1'b1;
               end
               shift_n = word;
               sdo_n   = word[FRAME_BITS-1];
               cnt_n   = '0;
               oe_n    = 1'b1;
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            // An abort wins over a coincident sck edge
            if (cs_rise) begin
               sdo_n   = 1'b0;
               oe_n    = 1'b0;
               state_n = IDLE;
            end else if (sck_fall) begin
               if (bit_cnt == LAST_BIT) begin
                  sdo_n   = 1'b0;
                  done_n  = 1'b1;
                  fcnt_n  = frame_cnt + 16'd1;
                  state_n = DONE;
`ifdef LTC2315_EMU_RAMP_EN
                  ramp_n  = ramp + 12'd1;
`endif
               end else begin
                  shift_n = shift_reg << 1;
                  sdo_n   = shift_reg[FRAME_BITS-2];
                  cnt_n   = bit_cnt + 1'b1;
               end
            end
         end
         DONE: begin
            sdo_n = 1'b0;
            if (cs_rise) begin
               oe_n    = 1'b0;
               state_n = IDLE;
            end
         end
         default: begin
            sdo_n   = 1'b0;
            oe_n    = 1'b0;
            state_n = IDLE;
         end
      endcase

      if (consume) begin
         buf_full_n = push;
         if (push) buf_data_n = sample_in;
      end else if (push) begin
         buf_full_n = 1'b1;
         buf_data_n = sample_in;
      end
   end

endmodule

// File: tb/tb_ltc2315_spi_emulator.sv
// tb_ltc2315_spi_emulator: drives CS/sck like the adc_ltc2315 reader (sck idles
// low, data read on sck rising edges) and compares against a queue-based model.
module tb_ltc2315_spi_emulator;

   logic        clk_100 = 1'b0;
   logic        reset, CS, sck, sample_valid;
   logic [11:0] sample_in;
   logic        sdo, sdo_oe, sample_ready, frame_done, underrun;
   logic [15:0] frame_cnt;
`ifdef LTC2315_EMU_RAMP_EN
   logic        ramp_mode = 1'b0;
`endif

   ltc2315_spi_emulator #(.DATA_W(12), .FRAME_BITS(16), .SYNC_STAGES(2)) dut (
      .clk_100(clk_100), .reset(reset),
`ifdef LTC2315_EMU_RAMP_EN
      .ramp_mode(ramp_mode),
`endif
      .CS(CS), .sck(sck), .sdo(sdo), .sdo_oe(sdo_oe),
      .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
      .frame_done(frame_done), .underrun(underrun), .frame_cnt(frame_cnt)
   );

   always #5 clk_100 = ~clk_100;

   int checks = 0, errors = 0;
   int done_seen = 0, und_seen = 0;

   // Model state: pending samples, last delivered sample, frame counter, ramp
   logic [11:0] mq[$];
   logic [11:0] m_last = '0;
   logic [15:0] m_fcnt = '0;
   logic [11:0] m_ramp = '0;

   always @(posedge clk_100) begin
      if (frame_done) done_seen++;
      if (underrun)   und_seen++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [11:0] v);
      @(negedge clk_100);
      sample_in    = v;
      sample_valid = 1'b1;
      check("push_ready", {31'b0, sample_ready}, 32'd1);
      @(negedge clk_100);
      sample_valid = 1'b0;
      mq.push_back(v);
   endtask

   task automatic run_frame(input int nfalls, input int half, input string tag, input bit ramp);
      logic [11:0] d;
      logic [15:0] w;
      logic [31:0] got, exp;
      bit          und, oe_ok, full;
      int          d0, u0;
      full = (nfalls >= 16);
      if (ramp) begin
         d = m_ramp; und = 0;
      end else if (mq.size() > 0) begin
         d = mq.pop_front(); m_last = d; und = 0;
      end else begin
         d = m_last; und = 1;
      end
      w   = {1'b0, d, 3'b000};
      exp = '0;
      for (int k = 0; k < nfalls; k++) exp = {exp[30:0], (k < 16) ? w[15-k] : 1'b0};
      d0 = done_seen; u0 = und_seen; got = '0; oe_ok = 1;

      @(negedge clk_100);
      CS = 1'b0;
      repeat (half) @(negedge clk_100);
      for (int i = 0; i < nfalls; i++) begin
         sck = 1'b1;
         got = {got[30:0], sdo};
         if (sdo_oe !== 1'b1) oe_ok = 0;
         repeat (half) @(negedge clk_100);
         sck = 1'b0;
         repeat (half) @(negedge clk_100);
      end
      CS = 1'b1;
      repeat (3) @(negedge clk_100);
      check({tag, "_idle"}, {30'b0, sdo, sdo_oe}, 32'd0);
      repeat (3) @(negedge clk_100);

      if (full) begin
         m_fcnt++;
         m_ramp++;
      end
      check({tag, "_data"}, got, exp);
      check({tag, "_oe"}, {31'b0, oe_ok}, 32'd1);
      check({tag, "_done"}, done_seen - d0, full ? 32'd1 : 32'd0);
      check({tag, "_underrun"}, und_seen - u0, und ? 32'd1 : 32'd0);
      check({tag, "_fcnt"}, {16'b0, frame_cnt}, {16'b0, m_fcnt});
      check({tag, "_ready"}, {31'b0, sample_ready}, (mq.size() == 0) ? 32'd1 : 32'd0);
   endtask

   initial begin
      reset = 1'b1; CS = 1'b1; sck = 1'b0; sample_valid = 1'b0; sample_in = '0;
      repeat (4) @(negedge clk_100);
      check("reset_state", {13'b0, sdo, sdo_oe, sample_ready, frame_done, underrun, frame_cnt},
            {13'b0, 5'b00100, 16'h0});
      reset = 1'b0;
      repeat (4) @(negedge clk_100);

      // Underrun right after reset replays the zero last-sample
      run_frame(16, 4, "empty0", 0);
      push(12'hA5C);
      run_frame(16, 4, "a5c", 0);
      run_frame(16, 4, "empty1", 0);

      // Full buffer stalls the second sample until the frame start frees it
      push(12'h123);
      @(negedge clk_100);
      sample_in = 12'h456; sample_valid = 1'b1;
      @(negedge clk_100);
      check("hold_ready", {31'b0, sample_ready}, 32'd0);
      fork
         run_frame(16, 4, "hold1", 0);
         begin
            for (int i = 0; i < 50 && !sample_ready; i++) @(negedge clk_100);
            check("hold_acc", {31'b0, sample_ready}, 32'd1);
            @(negedge clk_100);
            sample_valid = 1'b0;
            mq.push_back(12'h456);
         end
      join
      run_frame(16, 4, "hold2", 0);

      // Abort after 7 falls, then a clean frame
      push(12'h3C7);
      run_frame(7, 4, "abort", 0);
      push(12'h9E1);
      run_frame(16, 4, "post_abort", 0);

      // Over-long frame reads zeros past bit 15
      push(12'hFFF);
      run_frame(20, 4, "over", 0);

      // Reset mid-frame with a sample waiting in the buffer
      push(12'h777);
      @(negedge clk_100);
      CS = 1'b0;
      repeat (4) @(negedge clk_100);
      for (int i = 0; i < 3; i++) begin
         sck = 1'b1; repeat (4) @(negedge clk_100);
         sck = 1'b0; repeat (4) @(negedge clk_100);
      end
      push(12'h555);
      reset = 1'b1;
      @(negedge clk_100);
      check("mid_reset", {13'b0, sdo, sdo_oe, sample_ready, frame_done, underrun, frame_cnt},
            {13'b0, 5'b00100, 16'h0});
      CS = 1'b1; sck = 1'b0;
      repeat (3) @(negedge clk_100);
      reset = 1'b0;
      mq.delete(); m_last = '0; m_fcnt = '0; m_ramp = '0;
      repeat (4) @(negedge clk_100);
      run_frame(16, 4, "after_reset", 0);

`ifdef LTC2315_EMU_RAMP_EN
      // Ramp frames leave a buffered sample untouched
      push(12'h2B4);
      ramp_mode = 1'b1;
      for (int i = 0; i < 20; i++) run_frame(16, 4, "ramp", 1);
      ramp_mode = 1'b0;
      run_frame(16, 4, "ramp_buf", 0);
`endif

      // Randomized frames: optional push, random length, random sck rate
      for (int n = 0; n < 40; n++) begin
         int r, nf;
         if ($urandom_range(0, 1) == 1 && mq.size() == 0) push(12'($urandom));
         r  = $urandom_range(0, 9);
         nf = (r < 2) ? $urandom_range(1, 15) : ((r < 3) ? $urandom_range(17, 20) : 16);
         run_frame(nf, $urandom_range(4, 7), "rnd", 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
